// File: rtl/pulse_cnt_multi.sv
// Multi-channel gated pulse counter: counts synchronised edges on CH inputs while
// i_en is high, then latches the per-channel counts and overflow flags with a strobe.
module pulse_cnt_multi #(
    parameter int CH          = 4,
    parameter int CW          = 16,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   i_pulse,
    input  logic            i_en,
    input  logic [1:0]      i_edge_mode,
    input  logic            i_clr,
    output logic [CH*CW-1:0] o_cnt,
    output logic [CH-1:0]   o_ovf,
    output logic            o_valid,
    output logic            o_busy
);

    // state | meaning
    // IDLE  | window closed, waiting for en_q
    // ARM   | one cycle: clear working counters, capture edge mode
    // COUNT | window open, counting selected edges
    // LATCH | one cycle: copy working counters/ovf to outputs
    typedef enum logic [1:0] {IDLE, ARM, COUNT, LATCH} state_t;

    localparam logic [CW-1:0] ONES = '1;

    state_t          state;
    logic [CH-1:0]   sync_r [SYNC_STAGES];
    logic [CH-1:0]   prev_r;
    logic            en_q;
    logic            en_q_d;
    logic [1:0]      mode_q;
    logic [CW-1:0]   work [CH];
    logic [CH-1:0]   work_ovf;

    logic [CH-1:0]   rise;
    logic [CH-1:0]   fall;
    logic [CH-1:0]   hit;
    logic            en_rise;

    assign rise    = sync_r[SYNC_STAGES-1] & ~prev_r;
    assign fall    = ~sync_r[SYNC_STAGES-1] & prev_r;
    assign hit     = ({CH{mode_q[0]}} & rise) | ({CH{mode_q[1]}} & fall);
    assign en_rise = en_q & ~en_q_d;

    // Reset is active-high despite its name; it matches the surrounding codebase.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
            prev_r <= '0;
            en_q   <= 1'b0;
            en_q_d <= 1'b0;
        end else begin
            sync_r[0] <= i_pulse;
            for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
            prev_r <= sync_r[SYNC_STAGES-1];
            en_q   <= i_en;
            en_q_d <= en_q;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= IDLE;
            mode_q   <= 2'b00;
            work_ovf <= '0;
            for (int k = 0; k < CH; k++) work[k] <= '0;
            o_cnt    <= '0;
            o_ovf    <= '0;
            o_valid  <= 1'b0;
            o_busy   <= 1'b0;
        end else if (i_clr) begin
            state    <= IDLE;
            work_ovf <= '0;
            for (int k = 0; k < CH; k++) work[k] <= '0;
            o_cnt    <= '0;
            o_ovf    <= '0;
            o_valid  <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A level check as well as the edge lets a window reopened during LATCH start here.
                    if (en_rise || en_q) begin
                        state  <= ARM;
                        o_busy <= 1'b1;
                    end
                end
                ARM: begin
                    for (int k = 0; k < CH; k++) work[k] <= '0;
                    work_ovf <= '0;
                    mode_q   <= i_edge_mode;
                    state    <= COUNT;
                end
                COUNT: begin
                    for (int k = 0; k < CH; k++) begin
                        if (hit[k]) begin
                            if (work[k] == ONES) begin
                                work_ovf[k] <= 1'b1;
                                if (SATURATE == 0) work[k] <= '0;
                            end else begin
                                work[k] <= work[k] + 1'b1;
                            end
                        end
                    end
                    if (!en_q) begin
                        state  <= LATCH;
                        o_busy <= 1'b0;
                    end
                end
                LATCH: begin
                    for (int k = 0; k < CH; k++) o_cnt[k*CW +: CW] <= work[k];
                    o_ovf   <= work_ovf;
                    o_valid <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_cnt_multi.sv
// Scoreboard bench: three counter configurations share one stimulus stream; a
// per-window edge tally predicts each configuration's latched result.
module tb_pulse_cnt_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  i_pulse;
    logic        i_en;
    logic [1:0]  i_edge_mode;
    logic        i_clr;

    logic [63:0] cnt_a;
    logic [15:0] cnt_b, cnt_c;
    logic [3:0]  ovf_a, ovf_b, ovf_c;
    logic        v_a, v_b, v_c;
    logic        busy_a, busy_b, busy_c;

    typedef struct {
        logic [63:0] cnt;
        logic [3:0]  ovf;
    } exp_t;

    exp_t q_a[$], q_b[$], q_c[$];
    logic [63:0] last_a, last_b, last_c;
    int   raw[4];
    logic [1:0] cur_mode;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pulse_cnt_multi #(.CH(4), .CW(16), .SYNC_STAGES(2), .SATURATE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .i_pulse(i_pulse), .i_en(i_en),
        .i_edge_mode(i_edge_mode), .i_clr(i_clr),
        .o_cnt(cnt_a), .o_ovf(ovf_a), .o_valid(v_a), .o_busy(busy_a));

    pulse_cnt_multi #(.CH(4), .CW(4), .SYNC_STAGES(2), .SATURATE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .i_pulse(i_pulse), .i_en(i_en),
        .i_edge_mode(i_edge_mode), .i_clr(i_clr),
        .o_cnt(cnt_b), .o_ovf(ovf_b), .o_valid(v_b), .o_busy(busy_b));

    pulse_cnt_multi #(.CH(4), .CW(4), .SYNC_STAGES(3), .SATURATE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .i_pulse(i_pulse), .i_en(i_en),
        .i_edge_mode(i_edge_mode), .i_clr(i_clr),
        .o_cnt(cnt_c), .o_ovf(ovf_c), .o_valid(v_c), .o_busy(busy_c));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: an ideal count of n edges squeezed into a cw-bit register.
    function automatic void conv(input int n, input int cw, input bit sat,
                                 output logic [15:0] v, output logic ov);
        int mx;
        mx = (1 << cw) - 1;
        ov = (n > mx);
        if (n <= mx)  v = 16'(n);
        else if (sat) v = 16'(mx);
        else          v = 16'(n % (mx + 1));
    endfunction

    task automatic push_expected();
        exp_t ea, eb, ec;
        logic [15:0] v;
        logic o;
        ea.cnt = '0; eb.cnt = '0; ec.cnt = '0;
        ea.ovf = '0; eb.ovf = '0; ec.ovf = '0;
        for (int k = 0; k < 4; k++) begin
            conv(raw[k], 16, 1'b1, v, o); ea.cnt[k*16 +: 16] = v;      ea.ovf[k] = o;
            conv(raw[k], 4,  1'b1, v, o); eb.cnt[k*4  +: 4]  = v[3:0]; eb.ovf[k] = o;
            conv(raw[k], 4,  1'b0, v, o); ec.cnt[k*4  +: 4]  = v[3:0]; ec.ovf[k] = o;
        end
        q_a.push_back(ea); q_b.push_back(eb); q_c.push_back(ec);
        last_a = ea.cnt; last_b = eb.cnt; last_c = ec.cnt;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (v_a) begin
            if (q_a.size() == 0) chk("valid_a_unexpected", 64'd1, 64'd0);
            else begin
                e = q_a.pop_front();
                chk("cnt_a", cnt_a, e.cnt);
                chk("ovf_a", 64'(ovf_a), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (v_b) begin
            if (q_b.size() == 0) chk("valid_b_unexpected", 64'd1, 64'd0);
            else begin
                e = q_b.pop_front();
                chk("cnt_b", 64'(cnt_b), e.cnt);
                chk("ovf_b", 64'(ovf_b), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (v_c) begin
            if (q_c.size() == 0) chk("valid_c_unexpected", 64'd1, 64'd0);
            else begin
                e = q_c.pop_front();
                chk("cnt_c", 64'(cnt_c), e.cnt);
                chk("ovf_c", 64'(ovf_c), 64'(e.ovf));
            end
        end
    end

    task automatic open_window(input logic [1:0] mode);
        i_edge_mode = mode;
        cur_mode    = mode;
        i_en        = 1'b1;
        for (int k = 0; k < 4; k++) raw[k] = 0;
        repeat (8) @(negedge clk);
        chk("busy_in_window", 64'(busy_a), 64'd1);
    endtask

    // lo/hi of 0 picks a random legal width.
    task automatic pulses(input int n, input logic [3:0] fmask, input bit rnd,
                          input int lo, input int hi, input bit counted);
        logic [3:0] m;
        int l, h;
        for (int i = 0; i < n; i++) begin
            m = rnd ? 4'($urandom) : fmask;
            l = (lo == 0) ? int'($urandom_range(2, 5)) : lo;
            h = (hi == 0) ? int'($urandom_range(2, 5)) : hi;
            i_pulse = 4'b0000;
            repeat (l) @(negedge clk);
            i_pulse = m;
            repeat (h) @(negedge clk);
            if (counted)
                for (int k = 0; k < 4; k++)
                    if (m[k]) raw[k] += int'(cur_mode[0]) + int'(cur_mode[1]);
        end
        i_pulse = 4'b0000;
        repeat (8) @(negedge clk);
    endtask

    // open_end leaves a pulse high across the close: only its rising edge is inside.
    task automatic close_window(input bit open_end, input logic [3:0] omask, input int gap);
        if (open_end) begin
            i_pulse = omask;
            for (int k = 0; k < 4; k++) if (omask[k]) raw[k] += int'(cur_mode[0]);
            repeat (6) @(negedge clk);
        end
        i_en = 1'b0;
        push_expected();
        if (open_end) begin
            repeat (8) @(negedge clk);
            i_pulse = 4'b0000;
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_held(input string nm);
        chk({nm, "_a"}, cnt_a, last_a);
        chk({nm, "_b"}, 64'(cnt_b), last_b);
        chk({nm, "_c"}, 64'(cnt_c), last_c);
    endtask

    initial begin
        rst_n = 1'b1; i_en = 1'b0; i_pulse = '0; i_edge_mode = 2'b01; i_clr = 1'b0;
        cur_mode = 2'b01;
        last_a = '0; last_b = '0; last_c = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_cnt_a", cnt_a, 64'd0);
        chk("rst_ovf_a", 64'(ovf_a), 64'd0);
        chk("rst_valid", 64'(v_a | v_b | v_c), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        repeat (10) @(negedge clk);

        // 50 pulses of 500 ns low / 300 ns high on channels 1..3
        open_window(2'b01);
        pulses(50, 4'b1110, 1'b0, 50, 30, 1'b1);
        close_window(1'b0, 4'b0000, 12);
        chk("busy_after_close", 64'(busy_a), 64'd0);

        open_window(2'b01);
        pulses(69, 4'b0111, 1'b0, 0, 0, 1'b1);
        close_window(1'b0, 4'b0000, 12);

        // Gate closed: pulses must neither count nor disturb the latched result
        pulses(15, 4'b0001, 1'b0, 0, 0, 1'b0);
        check_held("held_idle");

        open_window(2'b11);
        pulses(10, 4'b1111, 1'b0, 0, 0, 1'b1);
        close_window(1'b0, 4'b0000, 12);

        open_window(2'b10);
        pulses(5, 4'b1111, 1'b0, 0, 0, 1'b1);
        close_window(1'b1, 4'b1111, 12);

        open_window(2'b01);
        pulses(20, 4'b1111, 1'b0, 0, 0, 1'b1);
        close_window(1'b0, 4'b0000, 12);

        open_window(2'b00);
        pulses(7, 4'b1111, 1'b0, 0, 0, 1'b1);
        close_window(1'b0, 4'b0000, 12);

        // Back-to-back windows separated by a single low cycle of i_en
        open_window(2'b01);
        pulses(6, 4'b0000, 1'b1, 0, 0, 1'b1);
        close_window(1'b0, 4'b0000, 1);
        open_window(2'b11);
        pulses(6, 4'b0000, 1'b1, 0, 0, 1'b1);
        close_window(1'b0, 4'b0000, 12);

        for (int w = 0; w < 10; w++) begin
            open_window(2'($urandom));
            pulses(int'($urandom_range(0, 40)), 4'b0000, 1'b1, 0, 0, 1'b1);
            close_window(1'($urandom), 4'($urandom), int'($urandom_range(1, 6)));
        end
        repeat (12) @(negedge clk);
        check_held("held_random");

        // Reset in the middle of a window: discarded, outputs clear at once
        open_window(2'b01);
        pulses(30, 4'b1111, 1'b0, 2, 2, 1'b1);
        #2;
        rst_n = 1'b1; i_en = 1'b0;
        #1;
        chk("midrst_cnt_a", cnt_a, 64'd0);
        chk("midrst_ovf_c", 64'(ovf_c), 64'd0);
        chk("midrst_busy", 64'(busy_a), 64'd0);
        last_a = '0; last_b = '0; last_c = '0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (12) @(negedge clk);
        check_held("held_after_rst");

        // Clear mid-window with i_en kept high: window re-opens afterwards
        open_window(2'b01);
        pulses(3, 4'b1111, 1'b0, 0, 0, 1'b1);
        close_window(1'b0, 4'b0000, 12);
        open_window(2'b01);
        pulses(8, 4'b1111, 1'b0, 0, 0, 1'b1);
        i_clr = 1'b1;
        @(negedge clk);
        chk("clr_cnt_a", cnt_a, 64'd0);
        chk("clr_cnt_b", 64'(cnt_b), 64'd0);
        chk("clr_busy", 64'(busy_a), 64'd0);
        i_clr = 1'b0;
        for (int k = 0; k < 4; k++) raw[k] = 0;
        repeat (6) @(negedge clk);
        chk("rearm_busy", 64'(busy_a), 64'd1);
        pulses(9, 4'b0000, 1'b1, 0, 0, 1'b1);
        close_window(1'b0, 4'b0000, 12);

        // Clear with i_en dropped together: no window, no strobe
        open_window(2'b01);
        pulses(4, 4'b1111, 1'b0, 0, 0, 1'b1);
        i_clr = 1'b1; i_en = 1'b0;
        @(negedge clk);
        chk("clr2_busy", 64'(busy_a), 64'd0);
        chk("clr2_cnt_c", 64'(cnt_c), 64'd0);
        repeat (2) @(negedge clk);
        i_clr = 1'b0;
        last_a = '0; last_b = '0; last_c = '0;
        repeat (12) @(negedge clk);
        check_held("held_after_clr");

        for (int i = 0; i < 50 && (q_a.size() + q_b.size() + q_c.size()) > 0; i++)
            @(negedge clk);
        chk("drain_a", 64'(q_a.size()), 64'd0);
        chk("drain_b", 64'(q_b.size()), 64'd0);
        chk("drain_c", 64'(q_c.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
